// File: rtl/countdown_timer_ctrl_pkg.sv
// countdown_timer_ctrl_pkg: shared state encoding and default clock rate for the countdown timer
package countdown_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CLK_FREQ = 100_000_000;

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider emitting a one-cycle half_tick every HALF_CYC enabled cycles
module tick_prescaler #(
    parameter int HALF_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic half_tick
);

    localparam int W = $clog2(HALF_CYC);
    localparam logic [W-1:0] LAST = W'(HALF_CYC - 1);

    logic [W-1:0] cnt;

    assign half_tick = en && cnt == LAST;

    // Held at zero while disabled so every enabled stretch starts a full period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= (clr || !en || half_tick) ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: loads a seconds value and counts it down with pause/resume/clear and display status
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int HALF_CYC = CLK_FREQ / 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic             done_pulse,
    output logic             blink,
    output logic             sec_tick
);

    state_t           state, nstate;
    logic [CNT_W-1:0] nrem;
    logic             phase, half_tick, go_run, sec, nblink, nsec, ndp;

    assign sec    = state == RUN && phase && half_tick;
    assign go_run = nstate == RUN && state != RUN;

    tick_prescaler #(.HALF_CYC(HALF_CYC)) u_pre (
        .clk       (clk),
        .rst       (rst),
        .clr       (go_run),
        .en        (state != IDLE),
        .half_tick (half_tick)
    );

    always_comb begin
        nstate = state;
        nrem   = remaining;
        nsec   = 1'b0;
        ndp    = 1'b0;
        if (clear) begin
            nstate = IDLE;
            nrem   = '0;
        end else if (pause && state == RUN) begin
            nstate = PAUSE;
        end else if (start && state == PAUSE) begin
            nstate = RUN;
        end else if (start && state != RUN) begin
            nstate = load_val != '0 ? RUN : DONE;
            nrem   = load_val;
            ndp    = load_val == '0;
        end else if (sec) begin
            nrem = remaining - CNT_W'(1);
            nsec = 1'b1;
            if (remaining == CNT_W'(1)) begin
                nstate = DONE;
                ndp    = 1'b1;
            end
        end
        // Entering PAUSE/DONE (or reloading into DONE) shows the display at once
        nblink = nstate == IDLE ? 1'b0 :
                 nstate == RUN  ? 1'b1 :
                 (nstate != state || ndp) ? 1'b1 :
                 half_tick ? !blink : blink;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            phase      <= 1'b0;
            blink      <= 1'b0;
            sec_tick   <= 1'b0;
            done_pulse <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nstate;
            remaining  <= nrem;
            phase      <= go_run ? 1'b0 : (state == RUN && half_tick) ? !phase : phase;
            blink      <= nblink;
            sec_tick   <= nsec;
            done_pulse <= ndp;
            running    <= nstate == RUN;
            done       <= nstate == DONE;
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: vector table, corner sequences and random run against a cycle-time model
module tb_countdown_timer_ctrl;

    localparam int H = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] remaining;
    logic       running, done, done_pulse, blink, sec_tick;

    countdown_timer_ctrl #(.CLK_FREQ(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .load_val   (load_val),
        .remaining  (remaining),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse),
        .blink      (blink),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int t = 0;
    int m_st = S_IDLE, m_rem = 0, m_run0 = 0, m_r = 0;
    bit m_blink = 0, m_sec = 0, m_dp = 0;

    typedef struct {
        bit s, p, c;
        int lv, n, rem;
        bit run, dn, dp, sec, bl;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_rem = 0; m_blink = 0; m_sec = 0; m_dp = 0;
    endtask

    // Ticks are derived from elapsed cycles since the last prescaler restart
    task automatic model(input bit s, input bit p, input bit c, input int lv);
        bit ht, stick, dp, sec;
        int ns, nr;
        ht    = m_st != S_IDLE && t > m_r && (t - m_r) % H == 0;
        stick = m_st == S_RUN && t > m_run0 && (t - m_run0) % (2 * H) == 0;
        ns = m_st; nr = m_rem; dp = 0; sec = 0;
        if (c) begin
            ns = S_IDLE; nr = 0;
        end else if (p && m_st == S_RUN) begin
            ns = S_PAUSE;
        end else if (s && m_st != S_RUN) begin
            if (m_st == S_PAUSE) ns = S_RUN;
            else if (lv != 0) begin ns = S_RUN; nr = lv; end
            else begin ns = S_DONE; nr = 0; dp = 1; end
        end else if (stick) begin
            nr = m_rem - 1; sec = 1;
            if (nr == 0) begin ns = S_DONE; dp = 1; end
        end
        m_blink = ns == S_IDLE ? 1'b0 : ns == S_RUN ? 1'b1 :
                  (ns != m_st || dp) ? 1'b1 : ht ? !m_blink : m_blink;
        if ((ns == S_RUN && m_st != S_RUN) || (m_st == S_IDLE && ns != S_IDLE)) m_r = t;
        if (ns == S_RUN && m_st != S_RUN) m_run0 = t;
        m_st = ns; m_rem = nr; m_sec = sec; m_dp = dp;
        t++;
    endtask

    task automatic step(input bit s, input bit p, input bit c, input logic [7:0] lv);
        start = s; pause = p; clear = c; load_val = lv;
        model(s, p, c, int'(lv));
        @(posedge clk);
        @(negedge clk);
        check("remaining", {24'd0, remaining}, m_rem);
        check("running", {31'd0, running}, (m_st == S_RUN) ? 1 : 0);
        check("done", {31'd0, done}, (m_st == S_DONE) ? 1 : 0);
        check("done_pulse", {31'd0, done_pulse}, {31'd0, m_dp});
        check("sec_tick", {31'd0, sec_tick}, {31'd0, m_sec});
        check("blink", {31'd0, blink}, {31'd0, m_blink});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'd0);
    endtask

    task automatic add(input bit s, p, c, input int lv, n, rem, input bit run, dn, dp, sec, bl);
        vec_t v;
        v.s = s; v.p = p; v.c = c; v.lv = lv; v.n = n; v.rem = rem;
        v.run = run; v.dn = dn; v.dp = dp; v.sec = sec; v.bl = bl;
        vq.push_back(v);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_remaining"}, {24'd0, remaining}, 0);
        check({pfx, "_running"}, {31'd0, running}, 0);
        check({pfx, "_done"}, {31'd0, done}, 0);
        check({pfx, "_done_pulse"}, {31'd0, done_pulse}, 0);
        check({pfx, "_sec_tick"}, {31'd0, sec_tick}, 0);
        check({pfx, "_blink"}, {31'd0, blink}, 0);
    endtask

    initial begin
        // load 3: ticks at +8/+16/+24, then DONE blinking every half second
        add(1,0,0,3,1, 3,1,0,0,0,1);
        add(0,0,0,0,7, 3,1,0,0,0,1);
        add(0,0,0,0,1, 2,1,0,0,1,1);
        add(0,0,0,0,8, 1,1,0,0,1,1);
        add(0,0,0,0,8, 0,0,1,1,1,1);
        add(0,0,0,0,1, 0,0,1,0,0,1);
        add(0,0,0,0,3, 0,0,1,0,0,0);
        add(0,0,0,0,4, 0,0,1,0,0,1);
        add(0,0,1,0,1, 0,0,0,0,0,0);
        // pause lands on the first second tick
        add(1,0,0,5,1, 5,1,0,0,0,1);
        add(0,0,0,0,7, 5,1,0,0,0,1);
        add(0,1,0,0,1, 5,0,0,0,0,1);
        add(0,0,1,0,1, 0,0,0,0,0,0);
        // zero load goes straight to DONE, then reload 2 from DONE
        add(1,0,0,0,1, 0,0,1,1,0,1);
        add(1,0,0,2,1, 2,1,0,0,0,1);
        add(0,0,0,0,8, 1,1,0,0,1,1);
        add(0,0,0,0,8, 0,0,1,1,1,1);
        add(0,0,1,0,1, 0,0,0,0,0,0);
        // clear mid-run and full-range load
        add(1,0,0,200,1, 200,1,0,0,0,1);
        add(0,0,0,0,12, 199,1,0,0,0,1);
        add(0,0,1,0,1, 0,0,0,0,0,0);
        add(1,0,0,255,1, 255,1,0,0,0,1);
        add(0,0,0,0,8, 254,1,0,0,1,1);
        add(0,0,1,0,1, 0,0,0,0,0,0);

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].s, vq[i].p, vq[i].c, 8'(vq[i].lv));
            idle(vq[i].n - 1);
            check($sformatf("vec%0d_remaining", i), {24'd0, remaining}, vq[i].rem);
            check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vq[i].run});
            check($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vq[i].dn});
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done_pulse}, {31'd0, vq[i].dp});
            check($sformatf("vec%0d_sec_tick", i), {31'd0, sec_tick}, {31'd0, vq[i].sec});
            check($sformatf("vec%0d_blink", i), {31'd0, blink}, {31'd0, vq[i].bl});
        end

        // pause at +10, resume at +30, next decrement at +38
        step(1, 0, 0, 8'd5);
        idle(9);
        step(0, 1, 0, 8'd0);
        check("pr_paused_rem", {24'd0, remaining}, 4);
        check("pr_paused_run", {31'd0, running}, 0);
        check("pr_blink_entry", {31'd0, blink}, 1);
        idle(2);
        check("pr_blink_t12", {31'd0, blink}, 0);
        idle(4);
        check("pr_blink_t16", {31'd0, blink}, 1);
        idle(13);
        step(1, 0, 0, 8'd0);
        check("pr_resume_run", {31'd0, running}, 1);
        idle(7);
        check("pr_rem_t37", {24'd0, remaining}, 4);
        idle(1);
        check("pr_rem_t38", {24'd0, remaining}, 3);
        check("pr_sec_t38", {31'd0, sec_tick}, 1);
        step(0, 0, 1, 8'd0);

        // clear and pause together while running
        step(1, 0, 0, 8'd7);
        idle(3);
        step(0, 1, 1, 8'd0);
        check_zero("clr_pause");

        // asynchronous reset between edges mid-run
        step(1, 0, 0, 8'd9);
        idle(5);
        #2 rst = 1'b0;
        #1 check_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 8'd1);
        check("post_rst_run", {31'd0, running}, 1);
        idle(8);
        check("post_rst_done", {31'd0, done}, 1);
        check("post_rst_dp", {31'd0, done_pulse}, 1);

        for (int k = 0; k < 2000; k++) begin
            int sel;
            logic [7:0] lv;
            sel = $urandom_range(0, 3);
            lv = sel == 0 ? 8'd0 : sel == 1 ? 8'd1 : sel == 2 ? 8'd255 : 8'($urandom_range(1, 6));
            step($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 59) == 0, lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
